dmac_axi_rd_resp: RTL and testbench

- AXI4 read-channel responder: accepts one AR burst at a time and expands it into per-beat byte addresses.
- Issues those addresses to a simple fixed-latency memory port and returns R beats with correct RID, RRESP and RLAST.
- Counterpart to the DMA burst splitter on the initiator side. Used as the memory-side endpoint in DMA subsystem benches and as the read port of on-chip SRAM.

---
 rtl/dmac_axi_rd_resp_if.sv | 49 ++++
 rtl/dmac_axi_rd_resp.sv | 188 ++++++++++++++++++
 tb/tb_dmac_axi_rd_resp.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_axi_rd_resp_if.sv
// AXI4 read-channel bundle (AR + R) shared between a read initiator and
// the dmac_axi_rd_resp endpoint. The axi4_pkg constants live here too so
// that the interface and the responder agree on field widths.

package axi4_pkg;
  localparam int LEN_BITS  = 8;
  localparam int SIZE_BITS = 3;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// Handshake: on each channel a transfer happens on the rising clk edge where
// valid and ready are both 1. Once valid is raised the sender holds valid and
// the payload stable until that edge; ready never waits on valid.
interface dmac_axi_rd_resp_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int ID_WD   = 4
);
  logic                           s_arvalid;
  logic                           s_arready;
  logic [ID_WD-1:0]               s_arid;
  logic [ADDR_WD-1:0]             s_araddr;
  logic [axi4_pkg::LEN_BITS-1:0]  s_arlen;
  logic [axi4_pkg::SIZE_BITS-1:0] s_arsize;
  logic [1:0]                     s_arburst;

  logic                           s_rvalid;
  logic                           s_rready;
  logic [ID_WD-1:0]               s_rid;
  logic [DATA_WD-1:0]             s_rdata;
  logic [1:0]                     s_rresp;
  logic                           s_rlast;

  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
  );

  modport slave (
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
  );
endinterface

// File: rtl/dmac_axi_rd_resp.sv
// AXI4 read responder: takes one AR burst at a time, walks its beat
// addresses against a 1-cycle-latency memory port and returns R beats
// through a 2-entry buffer. Illegal bursts answer SLVERR without touching
// memory.

module dmac_axi_rd_resp
  import axi4_pkg::*;
#(
  parameter int ADDR_WD    = 32,
  parameter int DATA_WD    = 32,
  parameter int ID_WD      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  dmac_axi_rd_resp_if.slave  s,
  output logic               mem_req,
  output logic [ADDR_WD-1:0] mem_addr,
  input  logic [DATA_WD-1:0] mem_rdata,
  output logic               dbg_state
);

  localparam int MAX_SIZE = $clog2(DATA_WD / 8);
  localparam int PTR_WD   = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t               state;
  logic [ID_WD-1:0]     b_id;
  logic [ADDR_WD-1:0]   b_addr;
  logic [LEN_BITS-1:0]  b_len;
  logic [LEN_BITS-1:0]  b_cnt;
  logic [SIZE_BITS-1:0] b_size;
  logic [1:0]           b_burst;
  logic                 b_err;

  // beat issued last cycle; its memory data arrives this cycle
  logic                 p_valid;
  logic [ID_WD-1:0]     p_id;
  logic                 p_err;
  logic                 p_last;

  logic [ID_WD-1:0]     f_id   [FIFO_DEPTH];
  logic [DATA_WD-1:0]   f_data [FIFO_DEPTH];
  logic [1:0]           f_resp [FIFO_DEPTH];
  logic                 f_last [FIFO_DEPTH];
  logic [PTR_WD-1:0]    wr_ptr;
  logic [PTR_WD-1:0]    rd_ptr;
  logic [PTR_WD:0]      f_count;

  logic                 push;
  logic                 pop;
  logic                 issue_ok;
  logic                 issue;
  logic                 ar_err;
  logic                 wrap_len_ok;

  logic [ADDR_WD-1:0]   step;
  logic [ADDR_WD-1:0]   aligned;
  logic [ADDR_WD-1:0]   wbytes;
  logic [ADDR_WD-1:0]   wrap_base;
  logic [ADDR_WD-1:0]   next_addr;

  assign push = p_valid;
  assign pop  = s.s_rvalid && s.s_rready;

  // Buffer slots already promised (stored + in flight) must stay below the
  // depth; a pop in the same cycle frees one slot for the new beat.
  assign issue_ok = ((f_count + {{PTR_WD{1'b0}}, p_valid}) < (PTR_WD + 1)'(FIFO_DEPTH)) || pop;
  assign issue    = (state == BURST) && issue_ok;

  assign mem_req   = issue && !b_err;
  assign mem_addr  = b_addr;
  assign dbg_state = state;

  assign s.s_arready = (state == IDLE);
  assign s.s_rvalid  = (f_count != '0);
  assign s.s_rid     = f_id[rd_ptr];
  assign s.s_rdata   = f_data[rd_ptr];
  assign s.s_rresp   = f_resp[rd_ptr];
  assign s.s_rlast   = f_last[rd_ptr];

  // Decode illegal requests at AR time so the whole burst answers SLVERR
  always_comb begin
    wrap_len_ok = (s.s_arlen == LEN_BITS'(1)) || (s.s_arlen == LEN_BITS'(3)) ||
                  (s.s_arlen == LEN_BITS'(7)) || (s.s_arlen == LEN_BITS'(15));
    ar_err = (int'(s.s_arsize) > MAX_SIZE) ||
             (s.s_arburst == 2'd3) ||
             ((s.s_arburst == BURST_WRAP) && !wrap_len_ok);
  end

  // Next beat address; only the first beat may be unaligned
  always_comb begin
    step      = ADDR_WD'(1) << b_size;
    aligned   = b_addr & ~(step - ADDR_WD'(1));
    wbytes    = (ADDR_WD'(b_len) + ADDR_WD'(1)) << b_size;
    wrap_base = aligned & ~(wbytes - ADDR_WD'(1));
    case (b_burst)
      BURST_INCR: next_addr = aligned + step;
      BURST_WRAP: next_addr = wrap_base | ((aligned + step) & (wbytes - ADDR_WD'(1)));
      default:    next_addr = b_addr;
    endcase
  end

  // Burst control: accept one AR, then step through its beats
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      b_id    <= '0;
      b_addr  <= '0;
      b_len   <= '0;
      b_cnt   <= '0;
      b_size  <= '0;
      b_burst <= '0;
      b_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s.s_arvalid) begin
            b_id    <= s.s_arid;
            b_addr  <= s.s_araddr;
            b_len   <= s.s_arlen;
            b_size  <= s.s_arsize;
            b_burst <= s.s_arburst;
            b_cnt   <= '0;
            b_err   <= ar_err;
            state   <= BURST;
          end
        end
        BURST: begin
          if (issue_ok) begin
            b_addr <= next_addr;
            b_cnt  <= b_cnt + LEN_BITS'(1);
            if (b_cnt == b_len) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sideband travels one cycle beside the memory read
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_id    <= '0;
      p_err   <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= issue;
      if (issue) begin
        p_id   <= b_id;
        p_err  <= b_err;
        p_last <= (b_cnt == b_len);
      end
    end
  end

  // R-beat buffer: push when memory data lands, pop on R handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_id[i]   <= '0;
        f_data[i] <= '0;
        f_resp[i] <= '0;
        f_last[i] <= 1'b0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      f_count <= '0;
    end else begin
      if (push) begin
        f_id[wr_ptr]   <= p_id;
        f_data[wr_ptr] <= p_err ? '0 : mem_rdata;
        f_resp[wr_ptr] <= p_err ? RESP_SLVERR : RESP_OKAY;
        f_last[wr_ptr] <= p_last;
        wr_ptr         <= wr_ptr + PTR_WD'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_WD'(1);
      case ({push, pop})
        2'b10:   f_count <= f_count + (PTR_WD + 1)'(1);
        2'b01:   f_count <= f_count - (PTR_WD + 1)'(1);
        default: f_count <= f_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_axi_rd_resp.sv
// Directed bench for dmac_axi_rd_resp: a 1-cycle memory model, a negedge
// monitor logging memory requests and accepted R beats, and one task per
// scenario comparing the logs against hand-computed expectations.

module tb_dmac_axi_rd_resp;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    int            cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int pcyc   = 0;

  logic [AW-1:0] mem_q[$];
  int            memc_q[$];
  beat_t         beat_q[$];
  beat_t         mon_b;

  dmac_axi_rd_resp_if #(.ADDR_WD(AW), .DATA_WD(DW), .ID_WD(IW)) bus ();

  dmac_axi_rd_resp #(.ADDR_WD(AW), .DATA_WD(DW), .ID_WD(IW), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / models ----------------
  always #5 clk = ~clk;

  always @(posedge clk) pcyc <= pcyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // data valid only the cycle after a request; junk otherwise
  always @(posedge clk) mem_rdata <= mem_req ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (mem_req) begin
      mem_q.push_back(mem_addr);
      memc_q.push_back(pcyc);
    end
    if (bus.s_rvalid && bus.s_rready) begin
      mon_b.id   = bus.s_rid;
      mon_b.data = bus.s_rdata;
      mon_b.resp = bus.s_rresp;
      mon_b.last = bus.s_rlast;
      mon_b.cyc  = pcyc;
      beat_q.push_back(mon_b);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at pcyc=%0d (required: finish earlier)", pcyc);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    bus.s_arvalid = 1'b0;
    bus.s_arid    = '0;
    bus.s_araddr  = '0;
    bus.s_arlen   = '0;
    bus.s_arsize  = '0;
    bus.s_arburst = '0;
    bus.s_rready  = 1'b1;
  endtask

  task automatic clear_logs();
    mem_q.delete();
    memc_q.delete();
    beat_q.delete();
  endtask

  // called just after a posedge; returns the cycle index of the AR handshake
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs);
    bus.s_arvalid = 1'b1;
    bus.s_arid    = id;
    bus.s_araddr  = addr;
    bus.s_arlen   = len;
    bus.s_arsize  = size;
    bus.s_arburst = burst;
    hs = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.s_arready) begin
        hs = pcyc;
        break;
      end
    end
    n_chk++;
    if (hs < 0) $display("FAIL ar_handshake id=%0d got no arready in 40 cycles, required arready=1", id);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.s_arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 300; i++) begin
      if (beat_q.size() >= n) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.s_arready !== 1'b1) $display("FAIL reset_arready got %b required 1", bus.s_arready);
    else n_pass++;
    n_chk++;
    if (bus.s_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b required 0", bus.s_rvalid);
    else n_pass++;
    n_chk++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0)
      $display("FAIL reset_mem got req=%b addr=%h required req=0 addr=0", mem_req, mem_addr);
    else n_pass++;
    n_chk++;
    if (bus.s_rlast !== 1'b0 || bus.s_rresp !== 2'd0 || bus.s_rid !== 4'd0 || bus.s_rdata !== 32'h0)
      $display("FAIL reset_r got last=%b resp=%0d id=%0d data=%h required all 0",
               bus.s_rlast, bus.s_rresp, bus.s_rid, bus.s_rdata);
    else n_pass++;
    n_chk++;
    if (dbg_state !== 1'b0) $display("FAIL reset_state got %b required 0 (IDLE)", dbg_state);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_incr();
    logic [31:0] exp_q[$];
    int hs;
    clear_logs();
    exp_q = '{32'h1002, 32'h1004, 32'h1008, 32'h100C};
    send_ar(4'd5, 32'h1002, 8'd3, 3'd2, 2'd1, hs);
    wait_beats(4);
    n_chk++;
    if (mem_q.size() != 4) $display("FAIL incr_req_count got %0d required 4", mem_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= mem_q.size()) $display("FAIL incr_addr%0d got none required %h", i, exp_q[i]);
      else if (mem_q[i] !== exp_q[i] || memc_q[i] != hs + 1 + i)
        $display("FAIL incr_addr%0d got %h @%0d required %h @%0d", i, mem_q[i], memc_q[i], exp_q[i], hs + 1 + i);
      else n_pass++;
    end
    n_chk++;
    if (beat_q.size() != 4) $display("FAIL incr_beat_count got %0d required 4", beat_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= beat_q.size()) $display("FAIL incr_beat%0d got none required one", i);
      else if (beat_q[i].id !== 4'd5 || beat_q[i].data !== mem_word(exp_q[i]) || beat_q[i].resp !== 2'd0 ||
               beat_q[i].last !== (i == 3) || beat_q[i].cyc != hs + 3 + i)
        $display("FAIL incr_beat%0d got id=%0d data=%h resp=%0d last=%b cyc=%0d required id=5 data=%h resp=0 last=%b cyc=%0d",
                 i, beat_q[i].id, beat_q[i].data, beat_q[i].resp, beat_q[i].last, beat_q[i].cyc,
                 mem_word(exp_q[i]), (i == 3), hs + 3 + i);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$];
    int hs;
    clear_logs();
    exp_q = '{32'h38, 32'h3C, 32'h30, 32'h34};
    send_ar(4'd1, 32'h38, 8'd3, 3'd2, 2'd2, hs);
    wait_beats(4);
    n_chk++;
    if (mem_q.size() != 4 || beat_q.size() != 4)
      $display("FAIL wrap_counts got req=%0d beats=%0d required 4/4", mem_q.size(), beat_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= mem_q.size() || i >= beat_q.size()) $display("FAIL wrap_beat%0d got none required addr %h", i, exp_q[i]);
      else if (mem_q[i] !== exp_q[i] || beat_q[i].id !== 4'd1 || beat_q[i].data !== mem_word(exp_q[i]) ||
               beat_q[i].resp !== 2'd0 || beat_q[i].last !== (i == 3))
        $display("FAIL wrap_beat%0d got addr=%h id=%0d data=%h resp=%0d last=%b required addr=%h id=1 data=%h resp=0 last=%b",
                 i, mem_q[i], beat_q[i].id, beat_q[i].data, beat_q[i].resp, beat_q[i].last,
                 exp_q[i], mem_word(exp_q[i]), (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_fixed();
    int hs;
    clear_logs();
    send_ar(4'd2, 32'h100, 8'd2, 3'd2, 2'd0, hs);
    wait_beats(3);
    n_chk++;
    if (mem_q.size() != 3 || beat_q.size() != 3)
      $display("FAIL fixed_counts got req=%0d beats=%0d required 3/3", mem_q.size(), beat_q.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (i >= mem_q.size() || i >= beat_q.size()) $display("FAIL fixed_beat%0d got none required addr 100", i);
      else if (mem_q[i] !== 32'h100 || beat_q[i].id !== 4'd2 || beat_q[i].data !== mem_word(32'h100) ||
               beat_q[i].last !== (i == 2))
        $display("FAIL fixed_beat%0d got addr=%h id=%0d data=%h last=%b required addr=100 id=2 data=%h last=%b",
                 i, mem_q[i], beat_q[i].id, beat_q[i].data, beat_q[i].last, mem_word(32'h100), (i == 2));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a;
    int hs;
    clear_logs();
    bus.s_rready = 1'b1;
    send_ar(4'd9, 32'h2000, 8'd7, 3'd2, 2'd1, hs);
    @(posedge clk);
    #1;
    bus.s_rready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_chk++;
    if (mem_q.size() != 2 || beat_q.size() != 0)
      $display("FAIL stall_fill got req=%0d beats=%0d required req=2 beats=0", mem_q.size(), beat_q.size());
    else n_pass++;
    n_chk++;
    if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== mem_word(32'h2000) || bus.s_rlast !== 1'b0)
      $display("FAIL stall_head got valid=%b data=%h last=%b required valid=1 data=%h last=0",
               bus.s_rvalid, bus.s_rdata, bus.s_rlast, mem_word(32'h2000));
    else n_pass++;
    bus.s_rready = 1'b1;
    wait_beats(8);
    n_chk++;
    if (mem_q.size() != 8 || beat_q.size() != 8)
      $display("FAIL stall_counts got req=%0d beats=%0d required 8/8", mem_q.size(), beat_q.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp_a = 32'h2000 + 32'(4 * i);
      n_chk++;
      if (i >= mem_q.size() || i >= beat_q.size()) $display("FAIL stall_beat%0d got none required addr %h", i, exp_a);
      else if (mem_q[i] !== exp_a || beat_q[i].id !== 4'd9 || beat_q[i].data !== mem_word(exp_a) ||
               beat_q[i].resp !== 2'd0 || beat_q[i].last !== (i == 7))
        $display("FAIL stall_beat%0d got addr=%h id=%0d data=%h resp=%0d last=%b required addr=%h id=9 data=%h resp=0 last=%b",
                 i, mem_q[i], beat_q[i].id, beat_q[i].data, beat_q[i].resp, beat_q[i].last,
                 exp_a, mem_word(exp_a), (i == 7));
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic [3:0]  t_id    [3] = '{4'd3, 4'd4, 4'd6};
    logic [31:0] t_addr  [3] = '{32'h40, 32'h38, 32'h80};
    logic [7:0]  t_len   [3] = '{8'd1, 8'd2, 8'd1};
    logic [2:0]  t_size  [3] = '{3'd2, 3'd2, 3'd3};
    logic [1:0]  t_burst [3] = '{2'd3, 2'd2, 2'd1};
    int hs;
    int nb;
    for (int k = 0; k < 3; k++) begin
      clear_logs();
      nb = int'(t_len[k]) + 1;
      send_ar(t_id[k], t_addr[k], t_len[k], t_size[k], t_burst[k], hs);
      wait_beats(nb);
      n_chk++;
      if (mem_q.size() != 0 || beat_q.size() != nb)
        $display("FAIL err%0d_counts got req=%0d beats=%0d required req=0 beats=%0d", k, mem_q.size(), beat_q.size(), nb);
      else n_pass++;
      for (int i = 0; i < nb; i++) begin
        n_chk++;
        if (i >= beat_q.size()) $display("FAIL err%0d_beat%0d got none required SLVERR beat", k, i);
        else if (beat_q[i].id !== t_id[k] || beat_q[i].data !== 32'h0 || beat_q[i].resp !== 2'd2 ||
                 beat_q[i].last !== (i == nb - 1))
          $display("FAIL err%0d_beat%0d got id=%0d data=%h resp=%0d last=%b required id=%0d data=0 resp=2 last=%b",
                   k, i, beat_q[i].id, beat_q[i].data, beat_q[i].resp, beat_q[i].last, t_id[k], (i == nb - 1));
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [3:0]  exp_id[3] = '{4'd3, 4'd4, 4'd4};
    logic        exp_last[3] = '{1'b1, 1'b0, 1'b1};
    int hs0;
    int hs1;
    clear_logs();
    exp_q = '{32'h400, 32'h500, 32'h504};
    send_ar(4'd3, 32'h400, 8'd0, 3'd2, 2'd1, hs0);
    send_ar(4'd4, 32'h500, 8'd1, 3'd2, 2'd1, hs1);
    wait_beats(3);
    n_chk++;
    if (hs1 != hs0 + 2) $display("FAIL b2b_ar_cycle got %0d required %0d", hs1, hs0 + 2);
    else n_pass++;
    n_chk++;
    if (mem_q.size() != 3 || beat_q.size() != 3)
      $display("FAIL b2b_counts got req=%0d beats=%0d required 3/3", mem_q.size(), beat_q.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (i >= mem_q.size() || i >= beat_q.size()) $display("FAIL b2b_beat%0d got none required addr %h", i, exp_q[i]);
      else if (mem_q[i] !== exp_q[i] || beat_q[i].id !== exp_id[i] || beat_q[i].data !== mem_word(exp_q[i]) ||
               beat_q[i].last !== exp_last[i])
        $display("FAIL b2b_beat%0d got addr=%h id=%0d data=%h last=%b required addr=%h id=%0d data=%h last=%b",
                 i, mem_q[i], beat_q[i].id, beat_q[i].data, beat_q[i].last,
                 exp_q[i], exp_id[i], mem_word(exp_q[i]), exp_last[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    clear_logs();
    bus.s_rready = 1'b0;
    send_ar(4'd6, 32'h800, 8'd7, 3'd2, 2'd1, hs);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.s_rvalid !== 1'b0 || bus.s_arready !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL midrst_outputs got rvalid=%b arready=%b mem_req=%b required 0/1/0",
               bus.s_rvalid, bus.s_arready, mem_req);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.s_rready = 1'b1;
    clear_logs();
    repeat (8) @(posedge clk);
    #1;
    n_chk++;
    if (beat_q.size() != 0 || mem_q.size() != 0)
      $display("FAIL midrst_stale got beats=%0d req=%0d required 0/0", beat_q.size(), mem_q.size());
    else n_pass++;
    send_ar(4'd7, 32'h900, 8'd0, 3'd2, 2'd1, hs);
    wait_beats(1);
    n_chk++;
    if (beat_q.size() != 1 || mem_q.size() != 1) $display("FAIL midrst_after_counts got beats=%0d req=%0d required 1/1",
                                                          beat_q.size(), mem_q.size());
    else if (mem_q[0] !== 32'h900 || beat_q[0].id !== 4'd7 || beat_q[0].data !== mem_word(32'h900) ||
             beat_q[0].resp !== 2'd0 || beat_q[0].last !== 1'b1)
      $display("FAIL midrst_after got addr=%h id=%0d data=%h resp=%0d last=%b required addr=900 id=7 data=%h resp=0 last=1",
               mem_q[0], beat_q[0].id, beat_q[0].data, beat_q[0].resp, beat_q[0].last, mem_word(32'h900));
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_bus();
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
